weight_load_ctrl: RTL and testbench
===================================

# weight_load_ctrl

Loader-side control that fills the weight and bias BRAM groups of the memory pool. It accepts one load command, consumes a stream of bank-row beats from the Load DMA, and emits the pool's `weight_write_*` and `bias_write_*` strobes. Each beat is routed to the correct bank and address. The block sits between the Load engine (upstream) and `mem_pool_top` (downstream).

## Interface
Parameters:
- `CHL_PARA`, 8, number of weight banks and units per bank
- `BANK_ADDR_WIDTH`, 12, address width of one bank
- `BANK_UNIT_WIDTH`, 8, bits per unit; beat width `BW = CHL_PARA*BANK_UNIT_WIDTH`

Ports:
- `clk` in 1: single clock
- `rst_p` in 1: reset, synchronous, active-high
- `cmd_valid_i` in 1 / `cmd_ready_o` out 1: command handshake
- `cmd_weit_base_i` in `BANK_ADDR_WIDTH`: first weight address
- `cmd_weit_rows_i` in `BANK_ADDR_WIDTH+1`: weight addresses to fill (0..depth)
- `cmd_bias_base_i` in `BANK_ADDR_WIDTH`: first bias address
- `cmd_bias_rows_i` in `BANK_ADDR_WIDTH+1`: bias rows to fill
- `s_data_i` in `BW` / `s_valid_i` in 1 / `s_ready_o` out 1: beat stream
- `weight_write_en_o` out 1, `weight_write_bank_o` out `CHL_PARA` (one-hot), `weight_write_addr_o` out `BANK_ADDR_WIDTH`, `weight_write_data_o` out `CHL_PARA*BW`
- `bias_write_en_o` out 1, `bias_write_bank_o` out 1, `bias_write_addr_o` out `BANK_ADDR_WIDTH`, `bias_write_data_o` out `BW`
- `busy_o` out 1: high outside IDLE
- `done_o` out 1: one-cycle pulse at command completion
- `err_o` out 1: sticky range error (see Configuration)

## Operation
- FSM states:
  - IDLE: `cmd_ready_o=1`. On command accept, latch all fields, clear the counters, and go to BIAS. If `bias_rows==0`, go to WEIT instead; if both row counts are 0, go to DONE.
  - BIAS: `s_ready_o=1`. Each accepted beat writes bias address `bias_base+k`, for `k=0..bias_rows-1`. After the last beat, go to WEIT, or to DONE if `weit_rows==0`.
  - WEIT: `s_ready_o=1`. Beats are ordered bank-minor. Beat `j` goes to bank `j mod CHL_PARA` at address `weit_base + j/CHL_PARA`. The bank counter wraps at `CHL_PARA-1` and advances the address counter. The state ends after `weit_rows*CHL_PARA` beats, then goes to DONE.
  - DONE: `done_o=1` for one cycle, then IDLE.
- Data routing:
  - `weight_write_data_o = {CHL_PARA{beat}}`; the one-hot bank selects the slice that is written.
  - `bias_write_data_o = beat`; `bias_write_bank_o = 1` whenever `bias_write_en_o` is high.
- Address arithmetic is modulo `2^BANK_ADDR_WIDTH`; with the error check compiled out, addresses wrap silently.
- `s_ready_o` is 0 in IDLE and DONE. Beats presented outside a command are not consumed.
- Stalls: `s_valid_i` low means no write that cycle. Counters hold.

## Timing
- All outputs are registered.
- Reset values: all `*_en_o`, `busy_o`, `done_o`, `err_o` = 0; `s_ready_o` = 0; `cmd_ready_o` = 1; addr/bank/data = 0. State resets to IDLE.
- Command accepted at edge `t` → `busy_o` high and `s_ready_o` high from cycle `t+1`.
- Beat accepted at edge `t` → the corresponding write strobe is high in cycle `t+1` for exactly one cycle. Sustained throughput is 1 beat/cycle.
- Last beat accepted at `t` → last write strobe and `done_o` both high in cycle `t+1`; `cmd_ready_o` high at `t+2`.
- Zero-length command accepted at `t` → `done_o` in cycle `t+1`, with no write strobes.
- `rst_p` asserted mid-load: on the next edge, abort to IDLE, drop all strobes, and discard counters. No `done_o` is issued.

## Configuration
- Macro `WLOAD_RANGE_CHECK_EN`.
- Defined: at command accept, check `base+rows > 2^BANK_ADDR_WIDTH` for either region. On failure:
  - set `err_o` (sticky until reset);
  - skip to DONE with no writes and `s_ready_o` held 0.
- Not defined: `err_o` is tied to 0, and addresses wrap.

## Structure
- Shared package `mem_pool_pkg`:
  - FSM state enum (IDLE/BIAS/WEIT/DONE);
  - derived width constants `BW` and `BANK_DEPTH`.
- One natural sub-module, `wload_addr_gen`. It holds the bank counter, address counter, and beat-remaining counter. Inputs: base, rows, step strobe. Outputs: bank one-hot, address, last-beat flag.

## Test plan
- `bias_rows=2` (base 0x010), `weit_rows=1` (base 0x000), `CHL_PARA=8`, 10 back-to-back beats:
  - bias writes at 0x010 and 0x011;
  - weight writes at addr 0x000 with banks 0x01 through 0x80;
  - `done_o` in the same cycle as the last write.
- `weit_rows=2`, base 0xFFF, 16 beats, check off: bank 0x80 at 0xFFF, then wrap to addr 0x000 bank 0x01.
- `s_valid_i` toggling 1-0-1-0: writes appear only one cycle after each accepted beat; counters hold during gaps.
- Both row counts 0: `done_o` one cycle after accept, zero write strobes, `cmd_ready_o` back high next cycle.
- `rst_p` pulsed after 3 of 8 weight beats: all outputs return to reset values next cycle, no `done_o`, and a new command is accepted normally.
- With `WLOAD_RANGE_CHECK_EN`, base 0xFFF and `weit_rows=2`: `err_o=1`, `done_o` pulse, and no writes.

Source files
------------

// File: rtl/mem_pool_pkg.sv
// Shared constants and the loader FSM state type for the memory-pool blocks.
// Default geometry: 8 banks x 8 units x 8 bits, 4K-deep banks.
package mem_pool_pkg;

    localparam int CHL_PARA_DEF        = 8;
    localparam int BANK_ADDR_WIDTH_DEF = 12;
    localparam int BANK_UNIT_WIDTH_DEF = 8;

    localparam int BW         = CHL_PARA_DEF * BANK_UNIT_WIDTH_DEF;
    localparam int BANK_DEPTH = 1 << BANK_ADDR_WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIAS = 2'd1,
        ST_WEIT = 2'd2,
        ST_DONE = 2'd3
    } wload_state_e;

    // Counter width able to index n items; never narrower than one bit.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Upstream side of the weight loader: load command plus the bank-row beat stream.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid
// and ready are both high; the source holds valid and payload until that edge.
interface weight_load_ctrl_if #(
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int BW              = 64
);
    logic                       cmd_valid_i;
    logic                       cmd_ready_o;
    logic [BANK_ADDR_WIDTH-1:0] cmd_weit_base_i;
    logic [BANK_ADDR_WIDTH:0]   cmd_weit_rows_i;
    logic [BANK_ADDR_WIDTH-1:0] cmd_bias_base_i;
    logic [BANK_ADDR_WIDTH:0]   cmd_bias_rows_i;

    logic [BW-1:0]              s_data_i;
    logic                       s_valid_i;
    logic                       s_ready_o;

    modport master (
        output cmd_valid_i, cmd_weit_base_i, cmd_weit_rows_i,
               cmd_bias_base_i, cmd_bias_rows_i, s_data_i, s_valid_i,
        input  cmd_ready_o, s_ready_o
    );

    modport slave (
        input  cmd_valid_i, cmd_weit_base_i, cmd_weit_rows_i,
               cmd_bias_base_i, cmd_bias_rows_i, s_data_i, s_valid_i,
        output cmd_ready_o, s_ready_o
    );

endinterface

// File: rtl/wload_addr_gen.sv
// Bank/address walker for one region: bank-minor order, BANKS beats per address.
// load_i restarts it at base_i with rows_i*BANKS beats remaining.
module wload_addr_gen
    import mem_pool_pkg::*;
#(
    parameter int BANKS = 8,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             load_i,
    input  logic [AW-1:0]    base_i,
    input  logic [AW:0]      rows_i,
    input  logic             step_i,
    output logic [BANKS-1:0] bank_oh_o,
    output logic [AW-1:0]    addr_o,
    output logic             last_o
);

    localparam int BCW = bits_for(BANKS);
    localparam int RW  = AW + 1 + BCW;

    logic [BCW-1:0] bank_q, bank_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [RW-1:0]  rem_q,  rem_d;

    always_comb begin
        bank_d = bank_q;
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            bank_d = '0;
            addr_d = base_i;
            rem_d  = RW'(rows_i) * RW'(BANKS);
        end else if (step_i && (rem_q != '0)) begin
            rem_d = rem_q - 1'b1;
            // Address moves only when the bank counter wraps; it wraps modulo 2^AW.
            if (bank_q == BCW'(BANKS - 1)) begin
                bank_d = '0;
                addr_d = addr_q + 1'b1;
            end else begin
                bank_d = bank_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            bank_q <= '0;
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            bank_q <= bank_d;
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign bank_oh_o = BANKS'(1) << bank_q;
    assign addr_o    = addr_q;
    assign last_o    = (rem_q == RW'(1));

endmodule

// File: rtl/weight_load_ctrl.sv
// Loader control filling the bias then weight BRAM groups from a beat stream.
// Optional WLOAD_RANGE_CHECK_EN rejects commands that would run past the bank end.
module weight_load_ctrl
    import mem_pool_pkg::*;
#(
    parameter int CHL_PARA        = CHL_PARA_DEF,
    parameter int BANK_ADDR_WIDTH = BANK_ADDR_WIDTH_DEF,
    parameter int BANK_UNIT_WIDTH = BANK_UNIT_WIDTH_DEF,
    localparam int BWL            = CHL_PARA * BANK_UNIT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_p,
    weight_load_ctrl_if.slave            up_if,

    output logic                         weight_write_en_o,
    output logic [CHL_PARA-1:0]          weight_write_bank_o,
    output logic [BANK_ADDR_WIDTH-1:0]   weight_write_addr_o,
    output logic [CHL_PARA*BWL-1:0]      weight_write_data_o,

    output logic                         bias_write_en_o,
    output logic                         bias_write_bank_o,
    output logic [BANK_ADDR_WIDTH-1:0]   bias_write_addr_o,
    output logic [BWL-1:0]               bias_write_data_o,

    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output wload_state_e                 dbg_state_o
);

    wload_state_e state_q, state_d;

    logic cmd_ready_q, cmd_ready_d;
    logic s_ready_q,   s_ready_d;
    logic busy_q,      busy_d;
    logic done_q,      done_d;
    logic weit_zero_q, weit_zero_d;

    logic                       wen_q,   wen_d;
    logic [CHL_PARA-1:0]        wbank_q, wbank_d;
    logic [BANK_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [BWL-1:0]             wbeat_q, wbeat_d;

    logic                       ben_q,   ben_d;
    logic                       bbank_q, bbank_d;
    logic [BANK_ADDR_WIDTH-1:0] baddr_q, baddr_d;
    logic [BWL-1:0]             bdata_q, bdata_d;

    logic cmd_fire, beat_fire, gen_load, bias_step, weit_step, range_bad;

    logic [CHL_PARA-1:0]        weit_bank_oh;
    logic [BANK_ADDR_WIDTH-1:0] weit_addr;
    logic                       weit_last;
    logic [0:0]                 bias_bank_oh;
    logic [BANK_ADDR_WIDTH-1:0] bias_addr;
    logic                       bias_last;

    assign cmd_fire  = up_if.cmd_valid_i && cmd_ready_q;
    assign beat_fire = up_if.s_valid_i && s_ready_q;

    wload_addr_gen #(.BANKS(1), .AW(BANK_ADDR_WIDTH)) u_bias_gen (
        .clk       (clk),
        .rst_p     (rst_p),
        .load_i    (gen_load),
        .base_i    (up_if.cmd_bias_base_i),
        .rows_i    (up_if.cmd_bias_rows_i),
        .step_i    (bias_step),
        .bank_oh_o (bias_bank_oh),
        .addr_o    (bias_addr),
        .last_o    (bias_last)
    );

    wload_addr_gen #(.BANKS(CHL_PARA), .AW(BANK_ADDR_WIDTH)) u_weit_gen (
        .clk       (clk),
        .rst_p     (rst_p),
        .load_i    (gen_load),
        .base_i    (up_if.cmd_weit_base_i),
        .rows_i    (up_if.cmd_weit_rows_i),
        .step_i    (weit_step),
        .bank_oh_o (weit_bank_oh),
        .addr_o    (weit_addr),
        .last_o    (weit_last)
    );

`ifdef WLOAD_RANGE_CHECK_EN
    localparam logic [BANK_ADDR_WIDTH+1:0] DEPTH_X = (BANK_ADDR_WIDTH+2)'(1) << BANK_ADDR_WIDTH;

    logic [BANK_ADDR_WIDTH+1:0] weit_end, bias_end;
    logic                       err_q, err_d;

    assign weit_end  = {2'b00, up_if.cmd_weit_base_i} + {1'b0, up_if.cmd_weit_rows_i};
    assign bias_end  = {2'b00, up_if.cmd_bias_base_i} + {1'b0, up_if.cmd_bias_rows_i};
    assign range_bad = (weit_end > DEPTH_X) || (bias_end > DEPTH_X);

    always_comb begin
        err_d = err_q;
        if (cmd_fire && range_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign range_bad = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gen_load    = 1'b0;
        bias_step   = 1'b0;
        weit_step   = 1'b0;
        weit_zero_d = weit_zero_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    gen_load    = 1'b1;
                    weit_zero_d = (up_if.cmd_weit_rows_i == '0);
                    if (range_bad) begin
                        state_d = ST_DONE;
                    end else if (up_if.cmd_bias_rows_i != '0) begin
                        state_d = ST_BIAS;
                    end else if (up_if.cmd_weit_rows_i != '0) begin
                        state_d = ST_WEIT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BIAS: begin
                if (beat_fire) begin
                    bias_step = 1'b1;
                    if (bias_last) begin
                        state_d = weit_zero_q ? ST_DONE : ST_WEIT;
                    end
                end
            end
            ST_WEIT: begin
                if (beat_fire) begin
                    weit_step = 1'b1;
                    if (weit_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status and ready flops are precomputed from the next state so they are registered
    // yet line up with the state they describe.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        s_ready_d   = (state_d == ST_BIAS) || (state_d == ST_WEIT);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);

        wen_d   = weit_step;
        wbank_d = weit_step ? weit_bank_oh : '0;
        waddr_d = weit_step ? weit_addr : waddr_q;
        wbeat_d = weit_step ? up_if.s_data_i : wbeat_q;

        ben_d   = bias_step;
        bbank_d = bias_step & bias_bank_oh[0];
        baddr_d = bias_step ? bias_addr : baddr_q;
        bdata_d = bias_step ? up_if.s_data_i : bdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            weit_zero_q <= 1'b0;
            wen_q       <= 1'b0;
            wbank_q     <= '0;
            waddr_q     <= '0;
            wbeat_q     <= '0;
            ben_q       <= 1'b0;
            bbank_q     <= 1'b0;
            baddr_q     <= '0;
            bdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            weit_zero_q <= weit_zero_d;
            wen_q       <= wen_d;
            wbank_q     <= wbank_d;
            waddr_q     <= waddr_d;
            wbeat_q     <= wbeat_d;
            ben_q       <= ben_d;
            bbank_q     <= bbank_d;
            baddr_q     <= baddr_d;
            bdata_q     <= bdata_d;
        end
    end

    assign up_if.cmd_ready_o = cmd_ready_q;
    assign up_if.s_ready_o   = s_ready_q;

    // One beat register feeds every bank slice; the one-hot bank picks the live slice.
    assign weight_write_en_o   = wen_q;
    assign weight_write_bank_o = wbank_q;
    assign weight_write_addr_o = waddr_q;
    assign weight_write_data_o = {CHL_PARA{wbeat_q}};

    assign bias_write_en_o   = ben_q;
    assign bias_write_bank_o = bbank_q;
    assign bias_write_addr_o = baddr_q;
    assign bias_write_data_o = bdata_q;

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Randomized bench for weight_load_ctrl: a queue-based model of the expected write
// sequence, latency and done timing; covers range errors when WLOAD_RANGE_CHECK_EN is set.
module tb_weight_load_ctrl;
    import mem_pool_pkg::*;

    localparam int CP  = 8;
    localparam int AW  = 12;
    localparam int UW  = 8;
    localparam int BWL = CP * UW;
    localparam int WE  = CP + AW + BWL;
    localparam int BE  = AW + BWL;
`ifdef WLOAD_RANGE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_p;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    weight_load_ctrl_if #(.BANK_ADDR_WIDTH(AW), .BW(BWL)) up_if ();

    logic               weight_write_en_o;
    logic [CP-1:0]      weight_write_bank_o;
    logic [AW-1:0]      weight_write_addr_o;
    logic [CP*BWL-1:0]  weight_write_data_o;
    logic               bias_write_en_o;
    logic               bias_write_bank_o;
    logic [AW-1:0]      bias_write_addr_o;
    logic [BWL-1:0]     bias_write_data_o;
    logic               busy_o, done_o, err_o;
    wload_state_e       dbg_state_o;

    weight_load_ctrl #(.CHL_PARA(CP), .BANK_ADDR_WIDTH(AW), .BANK_UNIT_WIDTH(UW)) dut (
        .clk                 (clk),
        .rst_p               (rst_p),
        .up_if               (up_if),
        .weight_write_en_o   (weight_write_en_o),
        .weight_write_bank_o (weight_write_bank_o),
        .weight_write_addr_o (weight_write_addr_o),
        .weight_write_data_o (weight_write_data_o),
        .bias_write_en_o     (bias_write_en_o),
        .bias_write_bank_o   (bias_write_bank_o),
        .bias_write_addr_o   (bias_write_addr_o),
        .bias_write_data_o   (bias_write_data_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .err_o               (err_o),
        .dbg_state_o         (dbg_state_o)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_wen"},       weight_write_en_o, 0);
        check_val({pfx, "_wbank"},     weight_write_bank_o, 0);
        check_val({pfx, "_waddr"},     weight_write_addr_o, 0);
        check_val({pfx, "_wdata"},     weight_write_data_o, 0);
        check_val({pfx, "_ben"},       bias_write_en_o, 0);
        check_val({pfx, "_bbank"},     bias_write_bank_o, 0);
        check_val({pfx, "_baddr"},     bias_write_addr_o, 0);
        check_val({pfx, "_bdata"},     bias_write_data_o, 0);
        check_val({pfx, "_busy"},      busy_o, 0);
        check_val({pfx, "_done"},      done_o, 0);
        check_val({pfx, "_err"},       err_o, 0);
        check_val({pfx, "_cmd_ready"}, up_if.cmd_ready_o, 1);
        check_val({pfx, "_s_ready"},   up_if.s_ready_o, 0);
    endtask

    // ---------------- scoreboard ----------------
    logic [WE-1:0] exp_w_q[$];
    logic [BE-1:0] exp_b_q[$];
    int unsigned   exp_w_cyc_q[$];
    int unsigned   exp_b_cyc_q[$];

    bit          done_expected = 1'b0;
    int unsigned exp_done_cyc  = 32'hFFFF_FFFF;
    int          done_cnt      = 0;
    bit          err_model     = 1'b0;
    bit          rdy_chk       = 1'b0;

    logic [WE-1:0]     mw;
    logic [BE-1:0]     mb;
    logic [CP*BWL-1:0] mwdata;
    int unsigned       mc;

    always @(negedge clk) begin
        if (rdy_chk) begin
            check_val("cmd_ready_after_done", up_if.cmd_ready_o, 1);
            rdy_chk = 1'b0;
        end
        if (weight_write_en_o) begin
            if (exp_w_q.size() == 0) begin
                check_val("spurious_wwrite", 1, 0);
            end else begin
                mw     = exp_w_q.pop_front();
                mc     = exp_w_cyc_q.pop_front();
                mwdata = {CP{mw[BWL-1:0]}};
                check_val("wwrite_bank", weight_write_bank_o, mw[WE-1 -: CP]);
                check_val("wwrite_addr", weight_write_addr_o, mw[AW+BWL-1 -: AW]);
                check_val("wwrite_data", weight_write_data_o, mwdata);
                check_val("wwrite_cyc",  cyc, mc);
            end
        end
        if (bias_write_en_o) begin
            if (exp_b_q.size() == 0) begin
                check_val("spurious_bwrite", 1, 0);
            end else begin
                mb = exp_b_q.pop_front();
                mc = exp_b_cyc_q.pop_front();
                check_val("bwrite_bank", bias_write_bank_o, 1);
                check_val("bwrite_addr", bias_write_addr_o, mb[BE-1 -: AW]);
                check_val("bwrite_data", bias_write_data_o, mb[BWL-1:0]);
                check_val("bwrite_cyc",  cyc, mc);
            end
        end
        if (done_o) begin
            if (!done_expected) begin
                check_val("spurious_done", 1, 0);
            end else begin
                check_val("done_cyc",    cyc, exp_done_cyc);
                check_val("done_w_left", exp_w_q.size(), 0);
                check_val("done_b_left", exp_b_q.size(), 0);
                check_val("done_err",    err_o, err_model);
                done_cnt++;
                rdy_chk = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    // stop_at >= 0: pulse reset after that many accepted beats instead of finishing.
    task automatic run_cmd(input logic [AW-1:0] wb, input int wr,
                           input logic [AW-1:0] bb, input int br,
                           input int vmode, input int stop_at);
        int            n_beats, acc, tries, start_done, j;
        bit            rng_bad, v, fire;
        logic [BWL-1:0] d;
        logic [AW-1:0]  a;
        logic [CP-1:0]  bk;

        rng_bad = CHK_EN && ((int'(bb) + br > (1 << AW)) || (int'(wb) + wr > (1 << AW)));
        n_beats = rng_bad ? 0 : br + wr * CP;

        tries = 0;
        while (!up_if.cmd_ready_o && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        if (tries == 20) check_val("cmd_ready_timeout", 0, 1);

        start_done = done_cnt;
        up_if.cmd_weit_base_i = wb;
        up_if.cmd_weit_rows_i = (AW+1)'(wr);
        up_if.cmd_bias_base_i = bb;
        up_if.cmd_bias_rows_i = (AW+1)'(br);
        up_if.cmd_valid_i     = 1'b1;
        @(posedge clk); #1;
        up_if.cmd_valid_i = 1'b0;
        if (rng_bad) err_model = 1'b1;
        done_expected = 1'b1;
        exp_done_cyc  = (n_beats == 0) ? cyc : 32'hFFFF_FFFF;
        check_val("busy_after_accept",    busy_o, 1);
        check_val("s_ready_after_accept", up_if.s_ready_o, n_beats > 0);

        acc   = 0;
        tries = 0;
        while (acc < n_beats && tries < n_beats * 8 + 40) begin
            if (stop_at >= 0 && acc == stop_at) break;
            case (vmode)
                0:       v = 1'b1;
                1:       v = (tries % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = {$urandom, $urandom};
            up_if.s_valid_i = v;
            up_if.s_data_i  = d;
            fire = v && up_if.s_ready_o;
            @(posedge clk); #1;
            if (fire) begin
                if (acc < br) begin
                    a = bb + AW'(acc);
                    exp_b_q.push_back({a, d});
                    exp_b_cyc_q.push_back(cyc);
                end else begin
                    j = acc - br;
                    bk = '0;
                    bk[j % CP] = 1'b1;
                    a = wb + AW'(j / CP);
                    exp_w_q.push_back({bk, a, d});
                    exp_w_cyc_q.push_back(cyc);
                end
                acc++;
                if (acc == n_beats) exp_done_cyc = cyc;
            end
            tries++;
        end
        up_if.s_valid_i = 1'b0;

        if (stop_at >= 0) begin
            rst_p = 1'b1;
            @(posedge clk); #1;
            done_expected = 1'b0;
            err_model     = 1'b0;
            check_reset_vals("abort");
            check_val("abort_w_left", exp_w_q.size(), 0);
            rst_p = 1'b0;
            @(posedge clk); #1;
            check_val("abort_no_done", done_cnt, start_done);
            return;
        end

        if (acc < n_beats) check_val("beat_timeout", acc, n_beats);
        if (n_beats == 0) begin
            // Beats offered while no load is in progress must be refused.
            up_if.s_valid_i = 1'b1;
            for (int k = 0; k < 2; k++) begin
                check_val("s_ready_no_load", up_if.s_ready_o, 0);
                @(posedge clk); #1;
            end
            up_if.s_valid_i = 1'b0;
        end

        tries = 0;
        while (done_cnt == start_done && tries < 10) begin
            @(posedge clk); #1;
            tries++;
        end
        check_val("done_seen", done_cnt, start_done + 1);
        done_expected = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_p                 = 1'b1;
        up_if.cmd_valid_i     = 1'b0;
        up_if.cmd_weit_base_i = '0;
        up_if.cmd_weit_rows_i = '0;
        up_if.cmd_bias_base_i = '0;
        up_if.cmd_bias_rows_i = '0;
        up_if.s_valid_i       = 1'b0;
        up_if.s_data_i        = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        check_val("reset_state", dbg_state_o, ST_IDLE);
        rst_p = 1'b0;
        @(posedge clk); #1;

        run_cmd(12'h000, 1, 12'h010, 2, 0, -1);   // bias pair then one full weight row
        run_cmd(12'hFFF, 2, 12'h000, 0, 0, -1);   // wraps, or range error when checked
        run_cmd(12'h100, 1, 12'h020, 3, 1, -1);   // valid toggling with gaps
        run_cmd(12'h000, 0, 12'h000, 0, 0, -1);   // zero-length command
        run_cmd(12'h200, 1, 12'h000, 0, 0, 3);    // reset after 3 of 8 weight beats
        run_cmd(12'h040, 1, 12'h050, 1, 0, -1);   // normal command after abort

        for (int i = 0; i < 12; i++) begin
            run_cmd(AW'($urandom_range(0, 4095)), $urandom_range(0, 3),
                    AW'($urandom_range(0, 4095)), $urandom_range(0, 4),
                    2, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        check_val("end_w_left", exp_w_q.size(), 0);
        check_val("end_b_left", exp_b_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
